debug_slave_sysclk_cmdq: RTL and testbench
==========================================

Name: debug_slave_sysclk_cmdq

Overview:
- System-clock side of the Nios II debug slave, next generation; instruction width, data width, action-bit position and queue depth are all parametrised.
- Takes update-IR/update-DR strobes and the scan data register from the JTAG (tck) side, synchronises them into clk, and queues each completed DR scan as a command.
- Per-instruction one-hot take_action / take_no_action pulses are issued only when the CPU-side consumer accepts a command.
- Unlike the previous generation, commands are buffered with ready/valid back-pressure and overflow reporting, not fired unconditionally.

Parameters:
- DATA_W, 38, width of sr and jdo.
- IR_W, 2, virtual-JTAG instruction width; number of action channels is NCH = 2**IR_W.
- ACT_BIT, 34, jdo bit selecting action (1) or no-action (0); must be < DATA_W.
- SYNC_STAGES, 2, synchroniser flops per strobe; must be >= 2.
- FIFO_DEPTH, 4, command queue entries; power of 2, >= 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset; deasserts synchronously to clk.
- vs_uir  in  1  update-IR level from tck domain; asynchronous to clk.
- vs_udr  in  1  update-DR level from tck domain; asynchronous to clk.
- ir_in  in  IR_W  virtual instruction; stable while vs_uir is high.
- sr  in  DATA_W  scan data register; stable from vs_udr rise until the next scan.
- cmd_ready  in  1  consumer accepts the head command.
- clr_overflow  in  1  clears the overflow flag.
- cmd_valid  out  1  queue is non-empty.
- cmd_count  out  $clog2(FIFO_DEPTH+1)  number of entries in the queue.
- jdo  out  DATA_W  data of the last accepted command.
- jdo_ir  out  IR_W  instruction of the last accepted command.
- take_action  out  NCH  one-hot, one-cycle pulse.
- take_no_action  out  NCH  one-hot, one-cycle pulse.
- overflow  out  1  sticky flag: a command was dropped.

Behaviour:
- Reset: every output and internal flop goes to 0 (queue empty, ir_q = 0).
- Synchronisers: vs_uir and vs_udr each pass through SYNC_STAGES flops. A rising-edge detector on the last stage, against one extra delay flop, gives uir_p / udr_p, each high for exactly 1 clk per rising edge. Falling edges are ignored.
- Strobe latency: if vs_udr rises before edge k, udr_p is high in the cycle following edge k+SYNC_STAGES-1. With SYNC_STAGES = 2, udr_p follows edge k+1.
- uir_p: ir_q <= ir_in.
- udr_p push:
  - Pushes {ir_q, sr} into the queue, using the pre-update value of ir_q when uir_p and udr_p coincide.
  - The entry is visible (cmd_valid = 1) after the same edge.
  - End-to-end: vs_udr rise before edge k gives cmd_valid = 1 after edge k+SYNC_STAGES.
- Pop: occurs when cmd_valid && cmd_ready at an edge. At that edge:
  - jdo <= head data, jdo_ir <= head ir.
  - take_action <= onehot(head ir) if head data[ACT_BIT] = 1; otherwise take_no_action <= onehot(head ir).
  - Pulses last exactly 1 cycle and are 0 in every cycle not following a pop.
  - jdo and jdo_ir hold until the next pop.
- Full queue (cmd_count = FIFO_DEPTH) with udr_p and no pop: the new command is dropped, the queue is unchanged and overflow <= 1.
- Full queue with udr_p and a pop at the same edge: the push is accepted and cmd_count stays FIFO_DEPTH; no overflow.
- Empty queue: cmd_ready is ignored and no pulses occur. A push in an empty cycle cannot pop in that same cycle.
- Pointers wrap modulo FIFO_DEPTH. cmd_count = wr_count - rd_count, kept one bit wider than the pointers.
- overflow: clr_overflow clears it. If a drop and clr_overflow coincide, the set wins (overflow = 1).
- Asynchronous reset mid-operation: queued commands are discarded and no pulse is emitted on reset release. Synchroniser flops reset to 0, so a vs_udr that is already high at release produces exactly one udr_p.

Test Plan:
- Reset release, then ir_in = 2'b01 with a vs_uir pulse, then sr = 38'h04_0000_0001 with a vs_udr pulse; cmd_ready = 1.
  -> cmd_valid rises 2 clks after the vs_udr sample; next edge: jdo = 38'h04_0000_0001, jdo_ir = 1, take_action = 4'b0010 for 1 clk, cmd_count returns to 0.
- ir = 3, sr[34] = 0 -> take_no_action = 4'b1000, take_action = 0.
- cmd_ready = 0, 5 DR scans with sr = 1..5 -> cmd_count = 4, overflow = 1. Then cmd_ready = 1 -> 4 pops, jdo = 1,2,3,4 in order; value 5 never appears.
- Queue full; udr_p and cmd_ready = 1 land on the same edge -> cmd_count stays 4, overflow stays 0, pop order preserved.
- clr_overflow = 1 coinciding with a drop -> overflow = 1. clr_overflow alone -> overflow = 0 next cycle.
- reset_n = 0 with 3 entries queued and a vs_udr in flight -> all outputs 0 immediately. After release, no take_* pulse and cmd_count = 0, unless vs_udr is still high (then exactly 1 entry).

Source files
------------

// File: rtl/debug_slave_sysclk_cmdq.sv
// debug_slave_sysclk_cmdq: synchronises JTAG update strobes into clk and queues DR scans as commands
// with ready/valid back-pressure, one-hot action pulses on pop and a sticky overflow flag.
module debug_slave_sysclk_cmdq #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int ACT_BIT     = 34,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              vs_uir,
    input  logic                              vs_udr,
    input  logic [IR_W-1:0]                   ir_in,
    input  logic [DATA_W-1:0]                 sr,
    input  logic                              cmd_ready,
    input  logic                              clr_overflow,
    output logic                              cmd_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   cmd_count,
    output logic [DATA_W-1:0]                 jdo,
    output logic [IR_W-1:0]                   jdo_ir,
    output logic [2**IR_W-1:0]                take_action,
    output logic [2**IR_W-1:0]                take_no_action,
    output logic                              overflow
);
    localparam int NCH = 2**IR_W;
    localparam int CW  = $clog2(FIFO_DEPTH+1);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int EW  = IR_W + DATA_W;

    logic [SYNC_STAGES:0] uir_s_q, uir_s_d, udr_s_q, udr_s_d;
    logic [IR_W-1:0]      ir_q, ir_d;
    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [EW-1:0]        mem_d [FIFO_DEPTH];
    logic [PW:0]          wr_q, wr_d, rd_q, rd_d, cnt;
    logic [DATA_W-1:0]    jdo_q, jdo_d;
    logic [IR_W-1:0]      jdo_ir_q, jdo_ir_d;
    logic [NCH-1:0]       act_q, act_d, nact_q, nact_d, oh;
    logic                 ovf_q, ovf_d;
    logic                 uir_p, udr_p, full, pop, push, drop;
    logic [EW-1:0]        head;

    always_comb begin
        uir_s_d  = {uir_s_q[SYNC_STAGES-1:0], vs_uir};
        udr_s_d  = {udr_s_q[SYNC_STAGES-1:0], vs_udr};
        // last sync stage against the extra delay flop: one pulse per rising edge
        uir_p    = uir_s_q[SYNC_STAGES-1] & ~uir_s_q[SYNC_STAGES];
        udr_p    = udr_s_q[SYNC_STAGES-1] & ~udr_s_q[SYNC_STAGES];
        ir_d     = uir_p ? ir_in : ir_q;
        cnt      = wr_q - rd_q;
        full     = cnt == (PW+1)'(FIFO_DEPTH);
        pop      = (cnt != '0) & cmd_ready;
        push     = udr_p & (~full | pop);
        drop     = udr_p & full & ~pop;
        head     = mem_q[rd_q[PW-1:0]];
        oh       = NCH'(1) << head[EW-1 -: IR_W];
        mem_d    = mem_q;
        if (push) mem_d[wr_q[PW-1:0]] = {ir_q, sr};
        wr_d     = push ? wr_q + 1'b1 : wr_q;
        rd_d     = pop ? rd_q + 1'b1 : rd_q;
        jdo_d    = pop ? head[DATA_W-1:0] : jdo_q;
        jdo_ir_d = pop ? head[EW-1 -: IR_W] : jdo_ir_q;
        act_d    = (pop & head[ACT_BIT]) ? oh : '0;
        nact_d   = (pop & ~head[ACT_BIT]) ? oh : '0;
        ovf_d    = drop | (ovf_q & ~clr_overflow);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_s_q  <= '0;
            udr_s_q  <= '0;
            ir_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            jdo_q    <= '0;
            jdo_ir_q <= '0;
            act_q    <= '0;
            nact_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            uir_s_q  <= uir_s_d;
            udr_s_q  <= udr_s_d;
            ir_q     <= ir_d;
            mem_q    <= mem_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            jdo_q    <= jdo_d;
            jdo_ir_q <= jdo_ir_d;
            act_q    <= act_d;
            nact_q   <= nact_d;
            ovf_q    <= ovf_d;
        end
    end

    assign cmd_valid      = cnt != '0;
    assign cmd_count      = CW'(cnt);
    assign jdo            = jdo_q;
    assign jdo_ir         = jdo_ir_q;
    assign take_action    = act_q;
    assign take_no_action = nact_q;
    assign overflow       = ovf_q;
endmodule

// File: tb/tb_debug_slave_sysclk_cmdq.sv
// tb_debug_slave_sysclk_cmdq: directed scenarios for the debug slave command queue.
module tb_debug_slave_sysclk_cmdq;
    logic        clk = 0, reset_n = 0, vs_uir = 0, vs_udr = 0, cmd_ready = 0, clr_overflow = 0;
    logic [1:0]  ir_in = 0;
    logic [37:0] sr = 0;
    logic        cmd_valid, overflow;
    logic [2:0]  cmd_count;
    logic [37:0] jdo;
    logic [1:0]  jdo_ir;
    logic [3:0]  take_action, take_no_action;
    int          n_cmp = 0, n_bad = 0;

    debug_slave_sysclk_cmdq dut (
        .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir_in), .sr(sr),
        .cmd_ready(cmd_ready), .clr_overflow(clr_overflow), .cmd_valid(cmd_valid), .cmd_count(cmd_count),
        .jdo(jdo), .jdo_ir(jdo_ir), .take_action(take_action), .take_no_action(take_no_action),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic do_uir(input logic [1:0] ir);
        @(negedge clk); ir_in = ir; vs_uir = 1;
        repeat (3) @(negedge clk);
        vs_uir = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_udr(input logic [37:0] d);
        @(negedge clk); sr = d; vs_udr = 1;
        repeat (3) @(negedge clk);
        vs_udr = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk); #1;
        n_cmp++; if ({cmd_valid, cmd_count, jdo, jdo_ir, take_action, take_no_action, overflow} !== 52'd0) begin n_bad++; $display("FAIL reset_outputs got valid=%b cnt=%0d jdo=%h ta=%b tna=%b ovf=%b want all 0", cmd_valid, cmd_count, jdo, take_action, take_no_action, overflow); end
        @(negedge clk); reset_n = 1;
    endtask

    task automatic test_action;
        @(negedge clk); cmd_ready = 1;
        do_uir(2'd1);
        @(negedge clk); sr = 38'h04_0000_0001; vs_udr = 1;
        @(posedge clk); #1;
        n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL act_valid_e0 got %b want 0", cmd_valid); end
        @(posedge clk); #1;
        n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL act_valid_e1 got %b want 0", cmd_valid); end
        @(posedge clk); #1;
        n_cmp++; if (cmd_valid !== 1'b1 || cmd_count !== 3'd1) begin n_bad++; $display("FAIL act_valid_e2 got valid=%b cnt=%0d want 1/1", cmd_valid, cmd_count); end
        @(posedge clk); #1;
        n_cmp++; if (jdo !== 38'h04_0000_0001 || jdo_ir !== 2'd1) begin n_bad++; $display("FAIL act_jdo got %h/%0d want 0400000001/1", jdo, jdo_ir); end
        n_cmp++; if (take_action !== 4'b0010 || take_no_action !== 4'b0000) begin n_bad++; $display("FAIL act_pulse got ta=%b tna=%b want 0010/0000", take_action, take_no_action); end
        n_cmp++; if (cmd_count !== 3'd0) begin n_bad++; $display("FAIL act_count got %0d want 0", cmd_count); end
        @(posedge clk); #1;
        n_cmp++; if (take_action !== 4'b0000) begin n_bad++; $display("FAIL act_pulse_len got %b want 0000", take_action); end
        vs_udr = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_no_action;
        do_uir(2'd3);
        @(negedge clk); sr = 38'h03_0000_0007; vs_udr = 1;
        repeat (4) @(posedge clk); #1;
        n_cmp++; if (take_no_action !== 4'b1000 || take_action !== 4'b0000) begin n_bad++; $display("FAIL noact_pulse got ta=%b tna=%b want 0000/1000", take_action, take_no_action); end
        n_cmp++; if (jdo !== 38'h03_0000_0007 || jdo_ir !== 2'd3) begin n_bad++; $display("FAIL noact_jdo got %h/%0d want 0300000007/3", jdo, jdo_ir); end
        @(posedge clk); #1;
        n_cmp++; if (take_no_action !== 4'b0000) begin n_bad++; $display("FAIL noact_pulse_len got %b want 0000", take_no_action); end
        vs_udr = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_overflow;
        @(negedge clk); cmd_ready = 0;
        for (int i = 1; i <= 5; i++) do_udr(38'(i));
        n_cmp++; if (cmd_count !== 3'd4 || overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_full got cnt=%0d ovf=%b want 4/1", cmd_count, overflow); end
        cmd_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (jdo !== 38'(i) || take_no_action !== 4'b1000) begin n_bad++; $display("FAIL ovf_pop%0d got jdo=%h tna=%b want %h/1000", i, jdo, take_no_action, 38'(i)); end
        end
        @(posedge clk); #1;
        n_cmp++; if (cmd_valid !== 1'b0 || jdo !== 38'd4 || take_no_action !== 4'b0000) begin n_bad++; $display("FAIL ovf_drained got valid=%b jdo=%h tna=%b want 0/4/0000", cmd_valid, jdo, take_no_action); end
    endtask

    task automatic test_clr_overflow;
        @(negedge clk); cmd_ready = 0;
        for (int i = 10; i <= 13; i++) do_udr(38'(i));
        n_cmp++; if (cmd_count !== 3'd4) begin n_bad++; $display("FAIL clr_fill got %0d want 4", cmd_count); end
        @(negedge clk); sr = 38'd14; vs_udr = 1;
        @(negedge clk);
        @(negedge clk); clr_overflow = 1;
        @(posedge clk); #1;
        n_cmp++; if (overflow !== 1'b1 || cmd_count !== 3'd4) begin n_bad++; $display("FAIL clr_vs_drop got ovf=%b cnt=%0d want 1/4", overflow, cmd_count); end
        @(negedge clk); clr_overflow = 0; vs_udr = 0;
        repeat (2) @(negedge clk);
        clr_overflow = 1;
        @(posedge clk); #1;
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL clr_alone got %b want 0", overflow); end
        @(negedge clk); clr_overflow = 0;
    endtask

    task automatic test_full_pop_push;
        logic [37:0] exp [4];
        exp = '{38'd11, 38'd12, 38'd13, 38'd20};
        @(negedge clk); sr = 38'd20; vs_udr = 1;
        @(negedge clk);
        @(negedge clk); cmd_ready = 1;
        @(posedge clk); #1;
        n_cmp++; if (cmd_count !== 3'd4 || overflow !== 1'b0 || jdo !== 38'd10) begin n_bad++; $display("FAIL fullpp got cnt=%0d ovf=%b jdo=%h want 4/0/a", cmd_count, overflow, jdo); end
        @(negedge clk); cmd_ready = 0; vs_udr = 0;
        repeat (2) @(negedge clk);
        cmd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (jdo !== exp[i]) begin n_bad++; $display("FAIL fullpp_pop%0d got %h want %h", i, jdo, exp[i]); end
        end
        @(posedge clk); #1;
        n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL fullpp_empty got %b want 0", cmd_valid); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk); cmd_ready = 0;
        for (int i = 30; i <= 32; i++) do_udr(38'(i));
        n_cmp++; if (cmd_count !== 3'd3) begin n_bad++; $display("FAIL rst_fill got %0d want 3", cmd_count); end
        @(negedge clk); sr = 38'd33; vs_udr = 1;
        @(posedge clk); #2; reset_n = 0; #1;
        n_cmp++; if ({cmd_valid, cmd_count, jdo, jdo_ir, take_action, take_no_action, overflow} !== 52'd0) begin n_bad++; $display("FAIL rst_async got valid=%b cnt=%0d jdo=%h ir=%0d want all 0", cmd_valid, cmd_count, jdo, jdo_ir); end
        @(negedge clk); vs_udr = 0; cmd_ready = 1;
        @(negedge clk); reset_n = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if ({take_action, take_no_action} !== 8'd0 || cmd_count !== 3'd0) begin n_bad++; $display("FAIL rst_release%0d got ta=%b tna=%b cnt=%0d want 0/0/0", i, take_action, take_no_action, cmd_count); end
        end
        @(negedge clk); reset_n = 0; sr = 38'h04_0000_00AA; vs_udr = 1;
        repeat (2) @(negedge clk);
        cmd_ready = 0; reset_n = 1;
        repeat (4) @(posedge clk); #1;
        n_cmp++; if (cmd_count !== 3'd1) begin n_bad++; $display("FAIL rst_udr_high got %0d want 1", cmd_count); end
        repeat (4) @(posedge clk); #1;
        n_cmp++; if (cmd_count !== 3'd1) begin n_bad++; $display("FAIL rst_udr_once got %0d want 1", cmd_count); end
        @(negedge clk); cmd_ready = 1;
        @(posedge clk); #1;
        n_cmp++; if (take_action !== 4'b0001 || jdo !== 38'h04_0000_00AA || jdo_ir !== 2'd0) begin n_bad++; $display("FAIL rst_udr_pop got ta=%b jdo=%h ir=%0d want 0001/04000000aa/0", take_action, jdo, jdo_ir); end
        vs_udr = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_action;
        test_no_action;
        test_overflow;
        test_clr_overflow;
        test_full_pop_push;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
